// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-unit definitions: compare operations, branch encodings
// and the 2-bit saturating counter helpers used by the predictor table.
package branch_resolve_unit_pkg;

  typedef enum logic [2:0] {
    CMP_EQ,
    CMP_NE,
    CMP_LT,
    CMP_GE,
    CMP_LTU,
    CMP_GEU,
    CMP_NOP
  } alu_cmp_op_e;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // Weak not-taken: the first taken outcome flips the prediction.
  localparam logic [1:0] BHT_RESET_VAL = 2'b01;

  // Maps a branch func3 field to its compare operation; the two
  // reserved encodings fall through to CMP_NOP.
  function automatic alu_cmp_op_e decode_cmp(input logic [2:0] func3);
    alu_cmp_op_e op;
    case (func3)
      F3_BEQ:  op = CMP_EQ;
      F3_BNE:  op = CMP_NE;
      F3_BLT:  op = CMP_LT;
      F3_BGE:  op = CMP_GE;
      F3_BLTU: op = CMP_LTU;
      F3_BGEU: op = CMP_GEU;
      default: op = CMP_NOP;
    endcase
    return op;
  endfunction

  // Saturating step of a 2-bit counter towards the resolved outcome.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] next;
    next = ctr;
    if (taken && ctr != 2'b11) begin
      next = ctr + 2'b01;
    end else if (!taken && ctr != 2'b00) begin
      next = ctr - 2'b01;
    end
    return next;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// 2-bit saturating branch history table: one combinational read port for
// fetch, one synchronous training port for resolve. A same-cycle read of
// the entry being trained returns the old counter value.
module bht_2bit
  import branch_resolve_unit_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam int ENTRIES = 2 ** IDX_W;

  logic [1:0] table_q [ENTRIES];

  assign rd_ctr = table_q[rd_idx];

  // Reset every counter to weak not-taken, otherwise train the indexed entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        table_q[i] <= BHT_RESET_VAL;
      end
    end else if (wr_en) begin
      table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch execution stage: resolves conditional branches, computes target
// and redirect, flags mispredictions, trains the BHT and counts retired
// branches. One registered output stage with valid/ready on both sides.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BHT_IDX_W = 6,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_rs1_val,
  input  logic [XLEN-1:0]  in_rs2_val,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target,
  output logic             out_mispredict,
  output logic [XLEN-1:0]  out_redirect,
  output logic             out_illegal,
  output logic             out_misalign,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]      opcode;
  logic [2:0]      func3;
  alu_cmp_op_e     cmp_op;
  logic [12:0]     imm13;
  logic [XLEN-1:0] imm_sext;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            cmp_true;
  logic            illegal;
  logic            taken;
  logic            misalign;
  logic            mispredict;
  logic [XLEN-1:0] redirect;
  logic            accept;
  logic            drain;
  logic [1:0]      pred_ctr;
  logic            unused_bits;

  assign opcode   = in_instr[6:0];
  assign func3    = in_instr[14:12];
  assign cmp_op   = decode_cmp(func3);
  assign imm13    = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_sext = {{(XLEN-13){imm13[12]}}, imm13};
  assign target   = in_pc + imm_sext;
  assign pc_plus4 = in_pc + PC_STEP;

  // Operand comparison selected by the decoded branch condition.
  always_comb begin
    cmp_true = 1'b0;
    case (cmp_op)
      CMP_EQ:  cmp_true = (in_rs1_val == in_rs2_val);
      CMP_NE:  cmp_true = (in_rs1_val != in_rs2_val);
      CMP_LT:  cmp_true = ($signed(in_rs1_val) <  $signed(in_rs2_val));
      CMP_GE:  cmp_true = ($signed(in_rs1_val) >= $signed(in_rs2_val));
      CMP_LTU: cmp_true = (in_rs1_val <  in_rs2_val);
      CMP_GEU: cmp_true = (in_rs1_val >= in_rs2_val);
      default: cmp_true = 1'b0;
    endcase
  end

  // A misaligned taken branch still resolves as taken with the bad target;
  // the trap is raised downstream, so it never counts as a mispredict.
  assign illegal    = (opcode != OPCODE_BRANCH) || (func3 == 3'd2) || (func3 == 3'd3);
  assign taken      = !illegal && cmp_true;
  assign misalign   = taken && target[1];
  assign mispredict = !illegal && !misalign && (taken != in_pred_taken);
  assign redirect   = taken ? target : pc_plus4;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign drain    = out_valid && out_ready && !out_illegal;

  assign pred_taken = pred_ctr[1];

  assign unused_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0], in_instr[24:15]};

  bht_2bit #(
    .IDX_W(BHT_IDX_W)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pred_pc[BHT_IDX_W+1:2]),
    .rd_ctr  (pred_ctr),
    .wr_en   (accept && !illegal),
    .wr_idx  (in_pc[BHT_IDX_W+1:2]),
    .wr_taken(taken)
  );

  // Output register: load on accept, hold under backpressure, clear on flush or drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_taken      <= 1'b0;
      out_target     <= '0;
      out_mispredict <= 1'b0;
      out_redirect   <= '0;
      out_illegal    <= 1'b0;
      out_misalign   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_taken      <= taken;
      out_target     <= target;
      out_mispredict <= mispredict;
      out_redirect   <= redirect;
      out_illegal    <= illegal;
      out_misalign   <= misalign;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating perf counters, bumped when a legal result leaves the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (drain) begin
      if (branch_cnt != '1) begin
        branch_cnt <= branch_cnt + CNT_ONE;
      end
      if (out_mispredict && mispred_cnt != '1) begin
        mispred_cnt <= mispred_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed testbench for branch_resolve_unit: compare ops at XLEN=32 and 64,
// backpressure, BHT training, illegal/misaligned beats, flush and reset.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        in_pred_taken;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_mispredict;
  logic [31:0] out_redirect;
  logic        out_illegal;
  logic        out_misalign;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  logic        w_pred_taken;
  logic        w_in_valid;
  logic        w_in_ready;
  logic [63:0] w_in_pc;
  logic [31:0] w_in_instr;
  logic [63:0] w_in_rs1_val;
  logic [63:0] w_in_rs2_val;
  logic        w_out_valid;
  logic        w_out_taken;
  logic [63:0] w_out_target;
  logic        w_out_mispredict;
  logic [63:0] w_out_redirect;
  logic        w_out_illegal;
  logic        w_out_misalign;
  logic [31:0] w_branch_cnt;
  logic [31:0] w_mispred_cnt;

  int tests_run;
  int tests_failed;
  int exp_branch;
  int exp_mispred;

  branch_resolve_unit #(.XLEN(32), .BHT_IDX_W(6), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .pred_pc(pred_pc), .pred_taken(pred_taken),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
    .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_target(out_target),
    .out_mispredict(out_mispredict), .out_redirect(out_redirect),
    .out_illegal(out_illegal), .out_misalign(out_misalign),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_resolve_unit #(.XLEN(64), .BHT_IDX_W(6), .CNT_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .pred_pc(64'h0), .pred_taken(w_pred_taken),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_pc(w_in_pc), .in_instr(w_in_instr),
    .in_rs1_val(w_in_rs1_val), .in_rs2_val(w_in_rs2_val),
    .in_pred_taken(1'b0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_taken(w_out_taken), .out_target(w_out_target),
    .out_mispredict(w_out_mispredict), .out_redirect(w_out_redirect),
    .out_illegal(w_out_illegal), .out_misalign(w_out_misalign),
    .branch_cnt(w_branch_cnt), .mispred_cnt(w_mispred_cnt)
  );

  // Free-running clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Builds a B-type branch word from a 13-bit byte offset and func3.
  function automatic logic [31:0] mk_b(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat for a single cycle, then withdraws it.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] instr,
                               input logic [31:0] rs1, input logic [31:0] rs2, input logic pred);
    in_pc         = pc;
    in_instr      = instr;
    in_rs1_val    = rs1;
    in_rs2_val    = rs2;
    in_pred_taken = pred;
    in_valid      = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Sends one beat and checks the registered result against hand-derived values.
  task automatic sendBeat(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic pred,
                          input logic e_taken, input logic [31:0] e_target, input logic e_mis,
                          input logic [31:0] e_redirect, input logic e_illegal,
                          input logic e_misalign, input logic drains);
    applyStimulus(pc, instr, rs1, rs2, pred);
    checkOutput({tag, ".valid"},    out_valid,      1'b1);
    checkOutput({tag, ".taken"},    out_taken,      e_taken);
    checkOutput({tag, ".target"},   out_target,     e_target);
    checkOutput({tag, ".mispred"},  out_mispredict, e_mis);
    checkOutput({tag, ".redirect"}, out_redirect,   e_redirect);
    checkOutput({tag, ".illegal"},  out_illegal,    e_illegal);
    checkOutput({tag, ".misalign"}, out_misalign,   e_misalign);
    if (drains && !e_illegal) exp_branch++;
    if (drains && e_mis) exp_mispred++;
  endtask

  // Checks both perf counters against the running tally.
  task automatic checkCounters(input string tag);
    checkOutput({tag, ".branch_cnt"},  branch_cnt,  32'(exp_branch));
    checkOutput({tag, ".mispred_cnt"}, mispred_cnt, 32'(exp_mispred));
  endtask

  // Main directed sequence.
  initial begin
    logic [31:0] bad_instr;
    tests_run = 0; tests_failed = 0; exp_branch = 0; exp_mispred = 0;
    clk = 1'b0; rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    pred_pc = 32'h40; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    in_rs1_val = '0; in_rs2_val = '0; in_pred_taken = 1'b0;
    w_in_valid = 1'b0; w_in_pc = '0; w_in_instr = '0; w_in_rs1_val = '0; w_in_rs2_val = '0;
    repeat (2) @(negedge clk);

    checkOutput("rst.out_valid", out_valid, 1'b0);
    checkOutput("rst.out_redirect", out_redirect, 32'h0);
    checkOutput("rst.pred_taken", pred_taken, 1'b0);
    checkOutput("rst.in_ready", in_ready, 1'b1);
    checkCounters("rst");
    rst = 1'b0;
    @(negedge clk);

    sendBeat("beq",  32'h100, mk_b(13'd16, 3'd0), 32'd5, 32'd5, 1'b0,
             1'b1, 32'h110, 1'b1, 32'h110, 1'b0, 1'b0, 1'b1);
    sendBeat("blt",  32'h200, mk_b(13'h1FF8, 3'd4), 32'hFFFF_FFFF, 32'd1, 1'b1,
             1'b1, 32'h1F8, 1'b0, 32'h1F8, 1'b0, 1'b0, 1'b1);
    sendBeat("bltu", 32'h200, mk_b(13'h1FF8, 3'd6), 32'hFFFF_FFFF, 32'd1, 1'b1,
             1'b0, 32'h1F8, 1'b1, 32'h204, 1'b0, 1'b0, 1'b1);
    sendBeat("bge",  32'h210, mk_b(13'd12, 3'd5), 32'd1, 32'hFFFF_FFFF, 1'b1,
             1'b1, 32'h21C, 1'b0, 32'h21C, 1'b0, 1'b0, 1'b1);
    sendBeat("bne",  32'h220, mk_b(13'd12, 3'd1), 32'd3, 32'd3, 1'b0,
             1'b0, 32'h22C, 1'b0, 32'h224, 1'b0, 1'b0, 1'b1);
    sendBeat("bgeu", 32'h230, mk_b(13'd12, 3'd7), 32'd1, 32'hFFFF_FFFF, 1'b0,
             1'b0, 32'h23C, 1'b0, 32'h234, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("idle.out_valid", out_valid, 1'b0);
    checkCounters("cmp");

    w_in_pc = 64'h1000; w_in_instr = mk_b(13'h1FF8, 3'd4);
    w_in_rs1_val = 64'hFFFF_FFFF_FFFF_FFFF; w_in_rs2_val = 64'd1; w_in_valid = 1'b1;
    @(negedge clk);
    checkOutput("x64.blt.taken", w_out_taken, 1'b1);
    checkOutput("x64.blt.target", w_out_target, 64'hFF8);
    checkOutput("x64.blt.redirect", w_out_redirect, 64'hFF8);
    w_in_instr = mk_b(13'h1FF8, 3'd6);
    @(negedge clk);
    w_in_valid = 1'b0;
    checkOutput("x64.bltu.taken", w_out_taken, 1'b0);
    checkOutput("x64.bltu.redirect", w_out_redirect, 64'h1004);
    w_in_rs1_val = 64'h1_0000_0000; w_in_instr = mk_b(13'd8, 3'd7); w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
    checkOutput("x64.bgeu_hi.taken", w_out_taken, 1'b1);
    checkOutput("x64.bgeu_hi.target", w_out_target, 64'h1008);

    out_ready = 1'b0;
    sendBeat("bp_a", 32'h300, mk_b(13'd8, 3'd0), 32'd1, 32'd2, 1'b0,
             1'b0, 32'h308, 1'b0, 32'h304, 1'b0, 1'b0, 1'b1);
    in_pc = 32'h400; in_instr = mk_b(13'h20, 3'd1); in_rs1_val = 32'd1; in_rs2_val = 32'd2;
    in_pred_taken = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp.in_ready", in_ready, 1'b0);
      checkOutput("bp.out_valid", out_valid, 1'b1);
      checkOutput("bp.hold_redirect", out_redirect, 32'h304);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp.release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("bp_b.valid", out_valid, 1'b1);
    checkOutput("bp_b.taken", out_taken, 1'b1);
    checkOutput("bp_b.target", out_target, 32'h420);
    exp_branch++; exp_mispred++;
    @(negedge clk);
    checkCounters("bp");

    sendBeat("bht_t1", 32'h40, mk_b(13'd16, 3'd0), 32'd0, 32'd0, 1'b0,
             1'b1, 32'h50, 1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    checkOutput("bht.after_t1", pred_taken, 1'b1);
    sendBeat("bht_t2", 32'h40, mk_b(13'd16, 3'd0), 32'd0, 32'd0, 1'b0,
             1'b1, 32'h50, 1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
    checkOutput("bht.after_t2", pred_taken, 1'b1);
    sendBeat("bht_n1", 32'h40, mk_b(13'd16, 3'd1), 32'd0, 32'd0, 1'b0,
             1'b0, 32'h50, 1'b0, 32'h44, 1'b0, 1'b0, 1'b1);
    checkOutput("bht.after_n1", pred_taken, 1'b1);
    sendBeat("ill_f3", 32'h40, mk_b(13'd16, 3'd2), 32'd0, 32'd0, 1'b1,
             1'b0, 32'h50, 1'b0, 32'h44, 1'b1, 1'b0, 1'b1);
    checkOutput("bht.after_ill", pred_taken, 1'b1);
    applyStimulus(32'h40, mk_b(13'd16, 3'd1), 32'd0, 32'd0, 1'b0);
    exp_branch++;
    checkOutput("bht.after_n2", pred_taken, 1'b0);
    checkOutput("bht_n2.redirect", out_redirect, 32'h44);

    bad_instr = mk_b(13'd16, 3'd0);
    bad_instr[6:0] = 7'b0110011;
    sendBeat("ill_op", 32'h700, bad_instr, 32'd7, 32'd7, 1'b1,
             1'b0, 32'h710, 1'b0, 32'h704, 1'b1, 1'b0, 1'b1);
    sendBeat("misal", 32'h500, mk_b(13'd2, 3'd0), 32'd9, 32'd9, 1'b0,
             1'b1, 32'h502, 1'b0, 32'h502, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkCounters("ill_misal");

    out_ready = 1'b0;
    sendBeat("fl_pend", 32'h600, mk_b(13'd16, 3'd0), 32'd4, 32'd4, 1'b0,
             1'b1, 32'h610, 1'b1, 32'h610, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b1; flush = 1'b1;
    in_pc = 32'h40; in_instr = mk_b(13'd16, 3'd0); in_rs1_val = 32'd0; in_rs2_val = 32'd0;
    in_pred_taken = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush.out_valid", out_valid, 1'b0);
    checkOutput("flush.bht", pred_taken, 1'b0);
    @(negedge clk);
    checkOutput("flush.out_valid_idle", out_valid, 1'b0);
    checkCounters("flush");

    out_ready = 1'b0;
    sendBeat("rst_pend", 32'h40, mk_b(13'd16, 3'd0), 32'd0, 32'd0, 1'b0,
             1'b1, 32'h50, 1'b1, 32'h50, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_pend.bht", pred_taken, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    exp_branch = 0; exp_mispred = 0;
    checkOutput("rst2.out_valid", out_valid, 1'b0);
    checkOutput("rst2.out_taken", out_taken, 1'b0);
    checkOutput("rst2.out_target", out_target, 32'h0);
    checkOutput("rst2.out_mispred", out_mispredict, 1'b0);
    checkOutput("rst2.pred_taken", pred_taken, 1'b0);
    checkCounters("rst2");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
